// File: rtl/peripheral_ahb_pkg.sv
// Shared AHB-Lite encodings and the master address-phase state type.
package peripheral_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        AP_IDLE   = 2'b00,
        AP_NONSEQ = 2'b01,
        AP_HOLD   = 2'b10
    } ap_state_t;

    // True when a request is too wide for the bus or misaligned for its size.
    function automatic logic req_illegal(input logic [2:0] size, input logic [2:0] max_size,
                                         input logic [2:0] addr_lo);
        logic [2:0] mask;
        if (size > max_size) return 1'b1;
        // size <= 3 here; 1 << 3 wraps to 0 so the mask becomes 3'b111
        mask = (3'd1 << size) - 3'd1;
        return (addr_lo & mask) != 3'd0;
    endfunction

endpackage

// File: rtl/peripheral_mpram_ahb_master.sv
// Pipelined single-transfer AHB-Lite master that feeds the mpram slave point to point.
module peripheral_mpram_ahb_master
    import peripheral_ahb_pkg::*;
#(
    parameter int unsigned PLEN        = 8,
    parameter int unsigned XLEN        = 32,
    parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [PLEN-1:0] req_addr,
    input  logic            req_we,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    output logic            HREADY,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADYOUT,
    input  logic            HRESP
);

    localparam logic [2:0] MaxSize = (XLEN == 64) ? HSIZE_DWORD : HSIZE_WORD;

    ap_state_t       ap_state;
    logic [XLEN-1:0] ap_wdata;   // write data riding with the request in the address phase
    logic            dp_pending;
    logic            dp_write;

    logic bad_req;
    logic outstanding;
    logic accept;
    logic issue;
    logic reject;
    logic ap_done;
    logic err_cycle1;

    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VALUE;
    assign HREADY    = HREADYOUT;

    // Acceptance and bus-phase qualifiers.
    always_comb begin
        bad_req     = req_illegal(req_size, MaxSize, req_addr[2:0]);
        outstanding = (ap_state != AP_IDLE) || dp_pending;
        // Rejects wait for an empty pipe so their response cannot overtake a real one
        req_ready   = ((ap_state == AP_IDLE) || HREADYOUT) && (ap_state != AP_HOLD) && !HRESET
                      && (!bad_req || !outstanding);
        accept      = req_valid && req_ready;
        issue       = accept && !bad_req;
        reject      = accept && bad_req;
        ap_done     = (HTRANS == HTRANS_NONSEQ) && HREADYOUT;
        err_cycle1  = dp_pending && HRESP && !HREADYOUT;
    end

    // Address-phase FSM with registered address/control outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_state <= AP_IDLE;
            HTRANS   <= HTRANS_IDLE;
            HSEL     <= 1'b0;
            HADDR    <= '0;
            HWRITE   <= 1'b0;
            HSIZE    <= 3'd0;
            ap_wdata <= '0;
        end else begin
            unique case (ap_state)
                AP_IDLE: begin
                    if (issue) begin
                        ap_state <= AP_NONSEQ;
                        HTRANS   <= HTRANS_NONSEQ;
                        HSEL     <= 1'b1;
                        HADDR    <= req_addr;
                        HWRITE   <= req_we;
                        HSIZE    <= req_size;
                        ap_wdata <= req_wdata;
                    end
                end
                AP_NONSEQ: begin
                    if (err_cycle1) begin
                        // Cancel the queued address phase; it is replayed after the error
                        ap_state <= AP_HOLD;
                        HTRANS   <= HTRANS_IDLE;
                        HSEL     <= 1'b0;
                    end else if (HREADYOUT) begin
                        if (issue) begin
                            HADDR    <= req_addr;
                            HWRITE   <= req_we;
                            HSIZE    <= req_size;
                            ap_wdata <= req_wdata;
                        end else begin
                            ap_state <= AP_IDLE;
                            HTRANS   <= HTRANS_IDLE;
                            HSEL     <= 1'b0;
                        end
                    end
                end
                AP_HOLD: begin
                    if (HREADYOUT) begin
                        ap_state <= AP_NONSEQ;
                        HTRANS   <= HTRANS_NONSEQ;
                        HSEL     <= 1'b1;
                    end
                end
                default: begin
                    ap_state <= AP_IDLE;
                    HTRANS   <= HTRANS_IDLE;
                    HSEL     <= 1'b0;
                end
            endcase
        end
    end

    // Data-phase tracking: HWDATA is loaded as the address phase completes and held.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_pending <= 1'b0;
            dp_write   <= 1'b0;
            HWDATA     <= '0;
        end else if (ap_done) begin
            dp_pending <= 1'b1;
            dp_write   <= HWRITE;
            HWDATA     <= ap_wdata;
        end else if (HREADYOUT) begin
            dp_pending <= 1'b0;
        end
    end

    // One-cycle response pulse for bus completions and local rejects.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else if (dp_pending && HREADYOUT) begin
            rsp_valid <= 1'b1;
            rsp_err   <= HRESP;
            rsp_rdata <= dp_write ? '0 : HRDATA;
        end else if (reject) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_peripheral_mpram_ahb_master.sv
// Directed bench for peripheral_mpram_ahb_master with a small word-memory slave.
module tb_peripheral_mpram_ahb_master;

    logic        HCLK;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    int vectors = 0;
    int errors  = 0;

    peripheral_mpram_ahb_master dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Word memory slave; HREADYOUT/HRESP come from the stimulus block.
    logic [31:0] mem [0:63];
    logic        s_dp;
    logic        s_we;
    logic [7:0]  s_addr;

    always @(posedge HCLK) begin
        if (HRESET) begin
            s_dp <= 1'b0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (HREADYOUT) begin
            if (s_dp && s_we && !HRESP) mem[s_addr[7:2]] <= HWDATA;
            s_dp   <= HSEL && (HTRANS == 2'b10);
            s_addr <= HADDR;
            s_we   <= HWRITE;
        end
    end

    assign HRDATA = mem[s_addr[7:2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge HCLK);
    endtask

    task automatic req(input logic we, input logic [7:0] addr, input logic [2:0] size,
                       input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wd;
    endtask

    initial begin
        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_size  = 3'd2;
        req_wdata = 32'h0;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;

        // Reset values and constant outputs
        cyc();
        cyc();
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hsel", HSEL, 1'b0);
        chk("rst_haddr", HADDR, 8'h00);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hsize", HSIZE, 3'd0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("hburst", HBURST, 3'b000);
        chk("hmastlock", HMASTLOCK, 1'b0);
        chk("hprot", HPROT, 4'b0011);
        req(1'b0, 8'h00, 3'd2, 32'h0);
        HREADYOUT = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("hready_lo", HREADY, 1'b0);
        req_valid = 1'b0;
        HREADYOUT = 1'b1;
        #1;
        chk("hready_hi", HREADY, 1'b1);
        HRESET = 1'b0;

        // Write 0xDEADBEEF to 0x10, then read it back
        cyc();
        req(1'b1, 8'h10, 3'd2, 32'hDEADBEEF);
        #1;
        chk("t1_ready", req_ready, 1'b1);
        cyc();
        chk("t1_w_htrans", HTRANS, 2'b10);
        chk("t1_w_hsel", HSEL, 1'b1);
        chk("t1_w_haddr", HADDR, 8'h10);
        chk("t1_w_hwrite", HWRITE, 1'b1);
        chk("t1_w_hsize", HSIZE, 3'd2);
        req(1'b0, 8'h10, 3'd2, 32'h0);
        cyc();
        chk("t1_r_htrans", HTRANS, 2'b10);
        chk("t1_r_hwrite", HWRITE, 1'b0);
        chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
        req_valid = 1'b0;
        cyc();
        chk("t1_idle_htrans", HTRANS, 2'b00);
        chk("t1_idle_hsel", HSEL, 1'b0);
        chk("t1_w_rsp_valid", rsp_valid, 1'b1);
        chk("t1_w_rsp_err", rsp_err, 1'b0);
        chk("t1_w_rsp_rdata", rsp_rdata, 32'h0);
        cyc();
        chk("t1_r_rsp_valid", rsp_valid, 1'b1);
        chk("t1_r_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t1_r_rsp_err", rsp_err, 1'b0);
        cyc();
        chk("t1_quiet", rsp_valid, 1'b0);

        // Back-to-back reads at 0x00..0x0C
        req(1'b0, 8'h00, 3'd2, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k <= 4) begin
                chk("t2_htrans", HTRANS, 2'b10);
                chk("t2_haddr", HADDR, 8'(4 * (k - 1)));
                if (k < 4) req_addr = 8'(4 * k);
                else req_valid = 1'b0;
            end else begin
                chk("t2_idle", HTRANS, 2'b00);
            end
            if (k >= 3) begin
                chk("t2_rsp_valid", rsp_valid, 1'b1);
                chk("t2_rsp_rdata", rsp_rdata, 32'hC0DE_0000 | 32'(k - 3));
            end else begin
                chk("t2_no_rsp", rsp_valid, 1'b0);
            end
        end
        cyc();
        chk("t2_quiet", rsp_valid, 1'b0);

        // Two wait states on a write data phase with a read pending
        req(1'b1, 8'h30, 3'd2, 32'h12345678);
        cyc();
        chk("t3_w_haddr", HADDR, 8'h30);
        req(1'b0, 8'h34, 3'd2, 32'h0);
        cyc();
        req_valid = 1'b0;
        HREADYOUT = 1'b0;
        #1;
        chk("t3_ready_stall", req_ready, 1'b0);
        chk("t3_haddr_0", HADDR, 8'h34);
        chk("t3_hwdata_0", HWDATA, 32'h12345678);
        for (int k = 1; k <= 2; k++) begin
            cyc();
            chk("t3_htrans_s", HTRANS, 2'b10);
            chk("t3_haddr_s", HADDR, 8'h34);
            chk("t3_hwdata_s", HWDATA, 32'h12345678);
            chk("t3_ready_s", req_ready, 1'b0);
            chk("t3_no_rsp", rsp_valid, 1'b0);
        end
        HREADYOUT = 1'b1;
        cyc();
        chk("t3_w_rsp_valid", rsp_valid, 1'b1);
        chk("t3_w_rsp_err", rsp_err, 1'b0);
        chk("t3_idle", HTRANS, 2'b00);
        cyc();
        chk("t3_r_rsp_valid", rsp_valid, 1'b1);
        chk("t3_r_rsp_rdata", rsp_rdata, 32'hC0DE_000D);

        // Slave error on write to 0x20 while read of 0x24 is in address phase
        req(1'b1, 8'h20, 3'd2, 32'hCAFEF00D);
        cyc();
        req(1'b0, 8'h24, 3'd2, 32'h0);
        cyc();
        req_valid = 1'b0;
        chk("t4_r_htrans", HTRANS, 2'b10);
        chk("t4_r_haddr", HADDR, 8'h24);
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        cyc();
        chk("t4_cancel", HTRANS, 2'b00);
        chk("t4_no_rsp", rsp_valid, 1'b0);
        HREADYOUT = 1'b1;
        #1;
        chk("t4_ready_hold", req_ready, 1'b0);
        cyc();
        HRESP = 1'b0;
        chk("t4_w_rsp_valid", rsp_valid, 1'b1);
        chk("t4_w_rsp_err", rsp_err, 1'b1);
        chk("t4_reissue", HTRANS, 2'b10);
        chk("t4_reissue_addr", HADDR, 8'h24);
        chk("t4_reissue_we", HWRITE, 1'b0);
        cyc();
        chk("t4_idle", HTRANS, 2'b00);
        chk("t4_gap", rsp_valid, 1'b0);
        cyc();
        chk("t4_r_rsp_valid", rsp_valid, 1'b1);
        chk("t4_r_rsp_err", rsp_err, 1'b0);
        chk("t4_r_rsp_rdata", rsp_rdata, 32'hC0DE_0009);

        // Misaligned WORD write is rejected locally
        cyc();
        req(1'b1, 8'h02, 3'd2, 32'h55555555);
        #1;
        chk("t5_ready", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        chk("t5_no_bus", HTRANS, 2'b00);
        chk("t5_rsp_valid", rsp_valid, 1'b1);
        chk("t5_rsp_err", rsp_err, 1'b1);
        cyc();
        chk("t5_no_bus2", HTRANS, 2'b00);
        chk("t5_quiet", rsp_valid, 1'b0);

        // Oversized request waits for the pipe to drain, then is rejected
        req(1'b0, 8'h00, 3'd2, 32'h0);
        cyc();
        req(1'b0, 8'h40, 3'd3, 32'h0);
        #1;
        chk("t5b_block_ap", req_ready, 1'b0);
        cyc();
        chk("t5b_block_dp", req_ready, 1'b0);
        chk("t5b_no_bus", HTRANS, 2'b00);
        cyc();
        chk("t5b_rd_rsp", rsp_valid, 1'b1);
        chk("t5b_rd_err", rsp_err, 1'b0);
        chk("t5b_ready", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        chk("t5b_rej_rsp", rsp_valid, 1'b1);
        chk("t5b_rej_err", rsp_err, 1'b1);
        chk("t5b_no_bus2", HTRANS, 2'b00);

        // Reset during a stalled write data phase
        cyc();
        req(1'b1, 8'h08, 3'd2, 32'hA5A5A5A5);
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("t6_dp_hwdata", HWDATA, 32'hA5A5A5A5);
        HREADYOUT = 1'b0;
        HRESET    = 1'b1;
        #1;
        chk("t6_ready_rst", req_ready, 1'b0);
        cyc();
        chk("t6_htrans", HTRANS, 2'b00);
        chk("t6_hsel", HSEL, 1'b0);
        chk("t6_haddr", HADDR, 8'h00);
        chk("t6_hwdata", HWDATA, 32'h0);
        chk("t6_hwrite", HWRITE, 1'b0);
        chk("t6_hsize", HSIZE, 3'd0);
        chk("t6_rsp_valid", rsp_valid, 1'b0);
        HRESET    = 1'b0;
        HREADYOUT = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_no_rsp", rsp_valid, 1'b0);
            chk("t6_no_bus", HTRANS, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_mpram_ahb_master.md
PERIPHERAL_MPRAM_AHB_MASTER -- requirements
Module: peripheral_mpram_ahb_master

Interface
REQ-001 SHALL have parameter PLEN, default 8, address width in bits.
REQ-002 SHALL have parameter XLEN, default 32, data width in bits; legal values are 32 and 64.
REQ-003 SHALL have parameter HPROT_VALUE, default 4'b0011, constant value driven on HPROT.
REQ-004 SHALL use one clock and a synchronous, active-high reset; both ports are listed first below.
REQ-005 Ports (name, direction, width, meaning):
  HCLK  in  1  clock; all logic samples on the rising edge.
  HRESET  in  1  synchronous reset, active-high.
  req_valid  in  1  request offered.
  req_ready  out  1  request accepted when req_valid and req_ready are both high.
  req_addr  in  PLEN  byte address.
  req_we  in  1  1 = write, 0 = read.
  req_size  in  3  AHB HSIZE encoding.
  req_wdata  in  XLEN  write data.
  rsp_valid  out  1  one-cycle response pulse; no backpressure.
  rsp_rdata  out  XLEN  read data, valid with rsp_valid.
  rsp_err  out  1  error flag, valid with rsp_valid.
  HSEL, HADDR[PLEN], HWDATA[XLEN], HWRITE, HSIZE[3], HBURST[3], HPROT[4], HTRANS[2], HMASTLOCK, HREADY  out  AHB-Lite master side, feeding the mpram slave.
  HRDATA[XLEN], HREADYOUT, HRESP  in  slave response.

Function
REQ-006 HBURST SHALL be SINGLE (3'b000), HMASTLOCK SHALL be 0 and HPROT SHALL be HPROT_VALUE at all times.
REQ-007 HREADY SHALL equal HREADYOUT combinationally, because this is a single-slave point-to-point connection.
REQ-008 The address phase SHALL be registered: a request accepted in cycle t drives HTRANS=NONSEQ, HSEL=1 and HADDR/HWRITE/HSIZE from cycle t+1.
REQ-009 The address phase SHALL complete in the first cycle in which HTRANS=NONSEQ and HREADYOUT=1; HADDR, HWRITE and HSIZE SHALL stay stable until then.
REQ-010 The data phase SHALL occupy the cycles after address-phase completion and SHALL end on HREADYOUT=1; HWDATA SHALL hold the captured req_wdata for the whole data phase.
REQ-011 The block SHALL pipeline transfers: the address phase of N+1 overlaps the data phase of N, so an unstalled stream sustains one transfer per cycle.
REQ-012 req_ready SHALL be (address slot empty OR HREADYOUT) AND state != AP_HOLD AND NOT HRESET.
REQ-013 With no request pending after an address-phase completion, the block SHALL drive HTRANS=IDLE and HSEL=0.
REQ-014 The address-phase FSM SHALL have three states:
  AP_IDLE -> AP_NONSEQ on acceptance.
  AP_NONSEQ -> AP_NONSEQ on completion with a new acceptance.
  AP_NONSEQ -> AP_IDLE on completion with no new request.
  AP_NONSEQ -> AP_HOLD on error cycle 1.
  AP_HOLD -> AP_NONSEQ after error cycle 2 when a request is held, otherwise -> AP_IDLE.
REQ-015 A data-phase-pending flag SHALL track the outstanding data phase, separately from the FSM.
REQ-016 On HRESP=1 with HREADYOUT=0 (error cycle 1), the block SHALL drive HTRANS=IDLE in the next cycle, retain the pending address-phase request, and reissue it after HRESP=1 with HREADYOUT=1 (error cycle 2).
REQ-017 rsp_valid SHALL pulse one cycle after each data-phase completion:
  rsp_err = HRESP sampled at completion.
  rsp_rdata = HRDATA sampled at completion for reads, 0 for writes.
REQ-018 A request with req_size > log2(XLEN/8), or with an address not aligned to req_size, SHALL NOT be issued on the bus.
  It is accepted only when no transfer is outstanding.
  It produces rsp_valid=1 and rsp_err=1 in the following cycle.
REQ-019 Responses SHALL be returned in acceptance order, and exactly one response SHALL be returned per accepted request.

Reset
REQ-020 While HRESET=1 at a clock edge, the following SHALL be reset:
  HTRANS=IDLE, HSEL=0, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0.
  rsp_valid=0, rsp_rdata=0, rsp_err=0.
  FSM=AP_IDLE, data-phase-pending flag cleared.
REQ-021 Reset asserted mid-transfer SHALL drop every outstanding transfer without producing a response; req_ready SHALL be 0 while HRESET=1.

Structure
REQ-022 HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HSIZE encodings (BYTE, HWORD, WORD, DWORD), HBURST_SINGLE and the FSM state typedef SHALL live in the shared package peripheral_ahb_pkg.
REQ-023 The block SHALL be a single module with no sub-modules; it is instantiated directly upstream of the mpram AHB slave.

Verification
REQ-024 Write then read, zero wait states:
  Stimulus: write 0xDEADBEEF to 0x10 (WORD), then read 0x10.
  Required: HTRANS sequence NONSEQ, NONSEQ, IDLE; the read response returns rsp_rdata=0xDEADBEEF with rsp_err=0.
REQ-025 Back-to-back stream:
  Stimulus: four reads at 0x00, 0x04, 0x08, 0x0C with req_valid held high.
  Required: four consecutive NONSEQ cycles and four rsp_valid pulses on consecutive cycles.
REQ-026 Wait states:
  Stimulus: slave holds HREADYOUT=0 for 2 cycles during a write data phase, with a read pending.
  Required: HADDR and HWDATA stay stable; req_ready=0 during the stall; the pending read is issued after the stall.
REQ-027 Slave error:
  Stimulus: two-cycle HRESP error on a write to 0x20 while a read of 0x24 is in its address phase.
  Required: HTRANS=IDLE for one cycle, the write responds with rsp_err=1, and the read is reissued and completes with rsp_err=0.
REQ-028 Local reject:
  Stimulus: WORD write to address 0x02.
  Required: no NONSEQ issued on the bus; rsp_valid=1 and rsp_err=1 one cycle after acceptance.
REQ-029 Reset mid-transfer:
  Stimulus: HRESET=1 during a data phase.
  Required: all outputs take their reset values at the next edge, and no rsp_valid follows.
